// File: rtl/vscale_mem_arbiter_pkg.sv
// vscale_mem_arbiter_pkg: arbiter FSM state encodings and RV32 memory size codes
package vscale_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_e;

    localparam logic [2:0] MEM_SIZE_B  = 3'd0;
    localparam logic [2:0] MEM_SIZE_H  = 3'd1;
    localparam logic [2:0] MEM_SIZE_W  = 3'd2;
    localparam logic [2:0] MEM_SIZE_BU = 3'd4;
    localparam logic [2:0] MEM_SIZE_HU = 3'd5;

endpackage

// File: rtl/vscale_mem_align_check.sv
// vscale_mem_align_check: flags size/address combinations that are misaligned (reusable in the LSU)
module vscale_mem_align_check
    import vscale_mem_arbiter_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o
);

    // halfwords need an even address, words need a 4-byte aligned address
    always_comb begin
        misaligned_o = ((size_i == MEM_SIZE_H || size_i == MEM_SIZE_HU) && addr_lo_i[0]) ||
                       (size_i == MEM_SIZE_W && addr_lo_i != 2'b00);
    end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter: shares one memory bus between fetch and data ports; optional VSCALE_MEM_ARB_PERF_EN adds stall counters
module vscale_mem_arbiter
    import vscale_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_en,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_wait,
    output logic                  imem_badmem_e,
    input  logic                  dmem_en,
    input  logic                  dmem_wen,
    input  logic [2:0]            dmem_size,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_wait,
    output logic                  dmem_badmem_e,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [2:0]            mem_req_size,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  mem_resp_err
`ifdef VSCALE_MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_imem_stall,
    output logic [31:0]           perf_dmem_stall
`endif
);

    arb_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
    logic                  stale_q, stale_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic                  misaligned, aligned, live, grant_d, grant_i, accept;
    logic                  stale_now, imem_done, dmem_done;

    vscale_mem_align_check u_align (
        .size_i       (dmem_size),
        .addr_lo_i    (dmem_addr[1:0]),
        .misaligned_o (misaligned)
    );

    // state, starvation counter, stale flag and issued fetch address
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            stale_q      <= 1'b0;
            iss_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            stale_q      <= stale_d;
            iss_addr_q   <= iss_addr_d;
        end
    end

    // grant, bus request, completion, port handshakes and next state
    always_comb begin
        live          = !reset;
        aligned       = !misaligned;
        grant_d       = dmem_en && aligned && starve_cnt_q < CNT_WIDTH'(STARVE_LIMIT);
        grant_i       = !grant_d && imem_en;
        mem_req_valid = live && state_q == ARB_IDLE && (grant_d || grant_i);
        mem_req_wen   = grant_d && dmem_wen;
        mem_req_size  = grant_d ? dmem_size : MEM_SIZE_W;
        mem_req_addr  = grant_d ? dmem_addr : imem_addr;
        mem_req_wdata = grant_d ? dmem_wdata : '0;
        accept        = mem_req_valid && mem_req_ready;
        stale_now     = stale_q || !imem_en || imem_addr != iss_addr_q;
        imem_done     = live && state_q == ARB_WAIT_I && mem_resp_valid && !stale_now;
        dmem_done     = live && state_q == ARB_WAIT_D && mem_resp_valid;
        imem_wait     = live && imem_en && !imem_done;
        dmem_wait     = live && dmem_en && aligned && !dmem_done;
        imem_badmem_e = imem_done && mem_resp_err;
        dmem_badmem_e = (live && dmem_en && misaligned) || (dmem_done && mem_resp_err);
        imem_rdata    = imem_done ? mem_resp_rdata : '0;
        dmem_rdata    = dmem_done ? mem_resp_rdata : '0;
        state_d       = state_q == ARB_IDLE ? (accept ? (grant_d ? ARB_WAIT_D : ARB_WAIT_I) : ARB_IDLE)
                                            : (mem_resp_valid ? ARB_IDLE : state_q);
        stale_d       = state_q == ARB_WAIT_I && !mem_resp_valid && stale_now;
        iss_addr_d    = accept && grant_i ? imem_addr : iss_addr_q;
        starve_cnt_d  = (!imem_en || (accept && grant_i)) ? '0
                      : accept ? starve_cnt_q + 1'b1 : starve_cnt_q;
    end

`ifdef VSCALE_MEM_ARB_PERF_EN
    logic [31:0] perf_imem_q, perf_dmem_q;

    // free-running stall-cycle counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_imem_q <= '0;
            perf_dmem_q <= '0;
        end else begin
            perf_imem_q <= perf_imem_q + 32'(imem_wait);
            perf_dmem_q <= perf_dmem_q + 32'(dmem_wait);
        end
    end

    assign perf_imem_stall = perf_imem_q;
    assign perf_dmem_stall = perf_dmem_q;
`endif

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// tb_vscale_mem_arbiter: cycle-by-cycle vector table plus a starvation sequence
module tb_vscale_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_en, dmem_en, dmem_wen;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic [2:0]  dmem_size;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        imem_wait, imem_badmem_e, dmem_wait, dmem_badmem_e;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [2:0]  mem_req_size;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_resp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vscale_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_wait      (imem_wait),
        .imem_badmem_e  (imem_badmem_e),
        .dmem_en        (dmem_en),
        .dmem_wen       (dmem_wen),
        .dmem_size      (dmem_size),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_wait      (dmem_wait),
        .dmem_badmem_e  (dmem_badmem_e),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_size   (mem_req_size),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    // flags = {mem_req_valid, imem_wait, dmem_wait, imem_badmem_e, dmem_badmem_e}
    typedef struct {
        logic        rst, ie;
        logic [31:0] ia;
        logic        de, dwen;
        logic [2:0]  ds;
        logic [31:0] da;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        err;
        logic [4:0]  flags;
        logic [31:0] ma, ir, dr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic ie, logic [31:0] ia, logic de, logic dwen,
                                logic [2:0] ds, logic [31:0] da, logic rdy, logic rv,
                                logic [31:0] rd, logic err, logic [4:0] flags,
                                logic [31:0] ma, logic [31:0] ir, logic [31:0] dr);
        vec_t v;
        v.rst = rst; v.ie = ie; v.ia = ia; v.de = de; v.dwen = dwen; v.ds = ds; v.da = da;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.err = err;
        v.flags = flags; v.ma = ma; v.ir = ir; v.dr = dr;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [4:0] got;
        reset = v.rst; imem_en = v.ie; imem_addr = v.ia;
        dmem_en = v.de; dmem_wen = v.dwen; dmem_size = v.ds; dmem_addr = v.da;
        dmem_wdata = 32'h5A5A_0000;
        mem_req_ready = v.rdy; mem_resp_valid = v.rv; mem_resp_rdata = v.rd; mem_resp_err = v.err;
        @(negedge clk);
        got = {mem_req_valid, imem_wait, dmem_wait, imem_badmem_e, dmem_badmem_e};
        checks++;
        if (got !== v.flags || imem_rdata !== v.ir || dmem_rdata !== v.dr ||
            (v.flags[4] && mem_req_addr !== v.ma)) begin
            errors++;
            $display("FAIL %s: got flags=%b addr=%h ir=%h dr=%h, want flags=%b addr=%h ir=%h dr=%h",
                     name, got, mem_req_addr, imem_rdata, dmem_rdata, v.flags, v.ma, v.ir, v.dr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t z;
        z = mk(0,0,0, 0,0,0,0, 0,0,0,0, 5'b00000, 0,0,0);
        // reset, with and without requests present
        tbl.push_back(mk(1,0,0,          0,0,0,0,          0,0,0,0,             5'b00000, 0,0,0));
        tbl.push_back(mk(1,1,32'h100,    0,0,0,0,          1,0,0,0,             5'b00000, 0,0,0));
        // fetch only: wait 1,1,0
        tbl.push_back(mk(0,1,32'h100,    0,0,0,0,          1,0,0,0,             5'b11000, 32'h100,0,0));
        tbl.push_back(mk(0,1,32'h100,    0,0,0,0,          0,0,0,0,             5'b01000, 0,0,0));
        tbl.push_back(mk(0,1,32'h100,    0,0,0,0,          0,1,32'h13,0,        5'b00000, 0,32'h13,0));
        tbl.push_back(z);
        // conflict: data first, fetch in IDLE after data response
        tbl.push_back(mk(0,1,32'h104,    1,0,2,32'h2000,   1,0,0,0,             5'b11100, 32'h2000,0,0));
        tbl.push_back(mk(0,1,32'h104,    1,0,2,32'h2000,   1,0,0,0,             5'b01100, 0,0,0));
        tbl.push_back(mk(0,1,32'h104,    1,0,2,32'h2000,   1,1,32'hCAFEF00D,0,  5'b01000, 0,0,32'hCAFEF00D));
        tbl.push_back(mk(0,1,32'h104,    0,0,0,0,          1,0,0,0,             5'b11000, 32'h104,0,0));
        tbl.push_back(mk(0,1,32'h104,    0,0,0,0,          1,1,32'h11111111,0,  5'b00000, 0,32'h11111111,0));
        tbl.push_back(z);
        // misaligned W store, misaligned HU load, aligned H store
        tbl.push_back(mk(0,0,0,          1,1,2,32'h2002,   1,0,0,0,             5'b00001, 0,0,0));
        tbl.push_back(mk(0,0,0,          1,0,5,32'h2001,   1,0,0,0,             5'b00001, 0,0,0));
        tbl.push_back(mk(0,0,0,          1,1,1,32'h2002,   1,0,0,0,             5'b10100, 32'h2002,0,0));
        tbl.push_back(mk(0,0,0,          1,1,1,32'h2002,   1,1,0,0,             5'b00000, 0,0,0));
        tbl.push_back(z);
        // bus error on a load
        tbl.push_back(mk(0,0,0,          1,0,2,32'h3000,   1,0,0,0,             5'b10100, 32'h3000,0,0));
        tbl.push_back(mk(0,0,0,          1,0,2,32'h3000,   1,1,32'hDEAD,1,      5'b00001, 0,0,32'hDEAD));
        tbl.push_back(z);
        // redirect 0x100 -> 0x200 while in WAIT_I
        tbl.push_back(mk(0,1,32'h100,    0,0,0,0,          1,0,0,0,             5'b11000, 32'h100,0,0));
        tbl.push_back(mk(0,1,32'h200,    0,0,0,0,          1,0,0,0,             5'b01000, 0,0,0));
        tbl.push_back(mk(0,1,32'h200,    0,0,0,0,          1,1,32'h0100DA7A,0,  5'b01000, 0,0,0));
        tbl.push_back(mk(0,1,32'h200,    0,0,0,0,          1,0,0,0,             5'b11000, 32'h200,0,0));
        tbl.push_back(mk(0,1,32'h200,    0,0,0,0,          1,1,32'h0200DA7A,0,  5'b00000, 0,32'h0200DA7A,0));
        tbl.push_back(z);
        // reset while in WAIT_D, then FSM must be back in IDLE
        tbl.push_back(mk(0,0,0,          1,0,2,32'h4000,   1,0,0,0,             5'b10100, 32'h4000,0,0));
        tbl.push_back(mk(1,0,0,          1,0,2,32'h4000,   1,0,0,0,             5'b00000, 0,0,0));
        tbl.push_back(z);
        tbl.push_back(mk(0,1,32'h300,    0,0,0,0,          0,0,0,0,             5'b11000, 32'h300,0,0));
        tbl.push_back(z);

        reset = 1'b1; imem_en = 0; imem_addr = 0; dmem_en = 0; dmem_wen = 0; dmem_size = 0;
        dmem_addr = 0; dmem_wdata = 0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_resp_rdata = 0; mem_resp_err = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // starvation: 4 data grants, then a forced fetch grant, then data again
        for (int g = 0; g < 6; g++) begin
            apply(mk(0,1,32'h500, 1,0,2,32'h6000, 1,0,0,0, 5'b11100,
                     g == 4 ? 32'h500 : 32'h6000, 0,0), $sformatf("starve_issue%0d", g));
            if (g == 4)
                apply(mk(0,1,32'h500, 1,0,2,32'h6000, 1,1,32'h1000 + g,0, 5'b00100,
                         0,32'h1000 + g,0), $sformatf("starve_resp%0d", g));
            else
                apply(mk(0,1,32'h500, 1,0,2,32'h6000, 1,1,32'h1000 + g,0, 5'b01000,
                         0,0,32'h1000 + g), $sformatf("starve_resp%0d", g));
        end
        apply(z, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
